// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Channel choice is software-selected (mode=0) or round-robin (mode=1); define STREAM_MUX_LOCK_EN for packet locking.
module stream_mux_n #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [N_CH-1:0]       in_last,
  output logic                  out_last,
`endif
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  // One extra bit so index arithmetic can exceed N_CH before the wrap.
  localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

  logic [WIDTH-1:0] ch_data [N_CH];

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] rr_last_q, rr_last_d;
`ifdef STREAM_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic             out_last_q, out_last_d;
`endif

  logic             ld;
  logic             xfer;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W:0]   idx_w;
  logic [SEL_W-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = xfer && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  assign ld   = !out_valid_q || out_ready;
  assign xfer = ld && grant_vld && !rst;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx_w     = '0;
    cand      = '0;
    if (!mode) begin
      if ({1'b0, sel} < N_CH_W) begin
        grant_vld = in_valid[sel];
        grant_idx = sel;
      end
    end
`ifdef STREAM_MUX_LOCK_EN
    else if (lock_q) begin
      // Mid-packet: only the channel that opened the packet may continue.
      grant_vld = in_valid[rr_last_q];
      grant_idx = rr_last_q;
    end
`endif
    else begin
      for (int off = 1; off <= N_CH; off++) begin
        idx_w = {1'b0, rr_last_q} + (SEL_W+1)'(off);
        if (idx_w >= N_CH_W) idx_w = idx_w - N_CH_W;
        cand = idx_w[SEL_W-1:0];
        if (!grant_vld && in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    rr_last_d   = rr_last_q;
`ifdef STREAM_MUX_LOCK_EN
    lock_d      = lock_q;
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
      if (mode) rr_last_d = grant_idx;
`ifdef STREAM_MUX_LOCK_EN
      out_last_d = in_last[grant_idx];
      if (mode) lock_d = !in_last[grant_idx];
`endif
    end else if (ld) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_last_q   <= SEL_W'(N_CH-1);
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      rr_last_q   <= rr_last_d;
`ifdef STREAM_MUX_LOCK_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
`ifdef STREAM_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: directed scenarios plus randomized traffic
// compared against a behavioural model of the selection and output-register rules.
module tb_stream_mux_n;
  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int SEL_W = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_ready;
`ifdef STREAM_MUX_LOCK_EN
  logic [N_CH-1:0]       in_last;
  logic                  out_last;
`endif

  int errors = 0;
  int checks = 0;

  // Model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_ch;
  int               m_rr;
  logic             m_lock;
  logic             m_last;

  always #5 clk = ~clk;

  stream_mux_n #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef STREAM_MUX_LOCK_EN
    .in_last  (in_last),
    .out_last (out_last),
`endif
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .out_ready(out_ready)
  );

  task automatic set_ch(input int i, input logic [WIDTH-1:0] d);
    in_data[i*WIDTH +: WIDTH] = d;
  endtask

  // Spec-level grant rule: sel in mode 0, locked channel, or first requester after m_rr.
  function automatic void model_grant(output logic gv, output int gi);
    gv = 1'b0;
    gi = 0;
    if (!mode) begin
      if (int'(sel) < N_CH && in_valid[sel]) begin
        gv = 1'b1;
        gi = int'(sel);
      end
    end else if (m_lock) begin
      gv = in_valid[m_rr];
      gi = m_rr;
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        int c;
        c = (m_rr + k) % N_CH;
        if (!gv && in_valid[c]) begin
          gv = 1'b1;
          gi = c;
        end
      end
    end
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++;
    if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
    @(negedge clk);
    rst = 1'b0; in_valid = 4'h0;
    $display("reset done");
  endtask

  task automatic test_sel_mode();
    @(negedge clk);
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; set_ch(2, 8'hA5); out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL sel2_in_ready got=%b exp=0100", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      errors++; $display("FAIL sel2_out got v=%b d=%h ch=%0d exp v=1 d=a5 ch=2", out_valid, out_data, out_ch);
    end
    $display("sel beat ch=%0d data=%h", out_ch, out_data);
    @(negedge clk);
    sel = 2'd1; in_valid = 4'b0001;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL sel1_idle_in_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
      errors++; $display("FAIL sel1_drain got v=%b d=%h exp v=0 d=a5", out_valid, out_data);
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) set_ch(i, WIDTH'(8'h10 + i));
      end
      #1;
      checks++;
      if (in_ready !== 4'(1 << (k % 4))) begin
        errors++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", k, in_ready, 4'(1 << (k % 4)));
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== 8'(8'h10 + k % 4)) begin
        errors++; $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d", k, out_valid, out_ch, out_data, k % 4);
      end
      $display("rr beat ch=%0d data=%h", out_ch, out_data);
    end
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; set_ch(3, 8'h5C); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", k, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h13 || out_ch !== 2'd3) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d exp v=1 d=13 ch=3", k, out_valid, out_data, out_ch);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1000", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5C || out_ch !== 2'd3) begin
      errors++; $display("FAIL bp_release_out got v=%b d=%h ch=%0d exp v=1 d=5c ch=3", out_valid, out_data, out_ch);
    end
    $display("bp beat ch=%0d data=%h", out_ch, out_data);
  endtask

  task automatic test_wrap_reset();
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b0010; set_ch(1, 8'h21); out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ch1_in_ready got=%b exp=0010", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 4'b0001; set_ch(0, 8'h30);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ch0_in_ready got=%b exp=0001", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h30) begin
      errors++; $display("FAIL wrap_out got v=%b ch=%0d d=%h exp v=1 ch=0 d=30", out_valid, out_ch, out_data);
    end
    $display("wrap beat ch=%0d data=%h", out_ch, out_data);
    @(negedge clk);
    rst = 1'b1; in_valid = 4'hF; set_ch(1, 8'h77);
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL midrst_in_ready got=%b exp=0000", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 8'h00) begin
      errors++; $display("FAIL midrst_out got v=%b ch=%0d d=%h exp v=0 ch=0 d=00", out_valid, out_ch, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_rr_restart got=%b exp=0001", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_ch !== 2'd0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_first_beat got v=%b ch=%0d exp v=1 ch=0", out_valid, out_ch);
    end
  endtask

`ifdef STREAM_MUX_LOCK_EN
  task automatic test_lock();
    logic [1:0] exp_ch [4];
    logic       exp_last [4];
    exp_ch   = '{2'd1, 2'd1, 2'd1, 2'd2};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    rst = 1'b1; in_valid = 4'h0; in_last = 4'h0;
    @(negedge clk);
    rst = 1'b0; mode = 1'b1; out_ready = 1'b1;
    set_ch(2, 8'hC0);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      in_valid = (b < 3) ? 4'b0110 : 4'b0100;
      set_ch(1, WIDTH'(8'hB0 + b));
      in_last[1] = (b == 2);
      #1;
      checks++;
      if (in_ready !== ((b < 3) ? 4'b0010 : 4'b0100)) begin
        errors++; $display("FAIL lock_in_ready[%0d] got=%b", b, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_ch !== exp_ch[b] || out_last !== exp_last[b] || out_valid !== 1'b1) begin
        errors++; $display("FAIL lock_out[%0d] got ch=%0d last=%b exp ch=%0d last=%b", b, out_ch, out_last, exp_ch[b], exp_last[b]);
      end
      $display("lock beat ch=%0d last=%b", out_ch, out_last);
    end
  endtask
`endif

  task automatic test_random();
    logic [N_CH-1:0] prev_xfer;
    logic            gv;
    int              gi;
    logic            ld;
    logic [N_CH-1:0] exp_ready;
    @(negedge clk);
    rst = 1'b1; in_valid = 4'h0;
`ifdef STREAM_MUX_LOCK_EN
    in_last = 4'h0;
`endif
    @(posedge clk); #1;
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_rr = N_CH - 1; m_lock = 1'b0; m_last = 1'b0;
    prev_xfer = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        if (!in_valid[i] || prev_xfer[i]) begin
          in_valid[i] = ($urandom_range(0, 2) != 0);
          set_ch(i, WIDTH'($urandom));
`ifdef STREAM_MUX_LOCK_EN
          in_last[i] = $urandom_range(0, 1) != 0;
`endif
        end
      end
      if ($urandom_range(0, 7) == 0) mode = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) sel = SEL_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ld = !m_valid || out_ready;
      model_grant(gv, gi);
      exp_ready = (ld && gv) ? N_CH'(1 << gi) : '0;
      #1;
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", cyc, in_ready, exp_ready);
      end
      @(posedge clk);
      if (exp_ready != 0) begin
        m_valid = 1'b1;
        m_data  = in_data[gi*WIDTH +: WIDTH];
        m_ch    = gi;
        if (mode) m_rr = gi;
`ifdef STREAM_MUX_LOCK_EN
        m_last = in_last[gi];
        if (mode) m_lock = !in_last[gi];
`endif
        $display("rand beat ch=%0d data=%h mode=%b", gi, m_data, mode);
      end else if (ld) begin
        m_valid = 1'b0;
      end
      prev_xfer = exp_ready;
      #1;
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_ch !== SEL_W'(m_ch)) begin
        errors++; $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d",
                           cyc, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
`ifdef STREAM_MUX_LOCK_EN
      checks++;
      if (out_last !== m_last) begin
        errors++; $display("FAIL rand_last[%0d] got=%b exp=%b", cyc, out_last, m_last);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
    in_last = '0;
`endif
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_rr = N_CH - 1; m_lock = 1'b0; m_last = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_sel_mode();
    test_round_robin();
    test_back_pressure();
    test_wrap_reset();
`ifdef STREAM_MUX_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised N-channel, WIDTH-bit streaming multiplexer with a registered output stage and valid/ready handshake on every input and on the output.
- Channel selection has two modes: software-selected through `sel`, or round-robin arbitration among the requesting channels.
- Sits between multiple producer streams and a single consumer, and replaces the fixed 4-bit combinational selector where back-pressure and fairness are needed.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 8, data bits per channel.
- SEL_W, $clog2(N_CH), select/channel-index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  N_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; combinational.
- mode  input  1  0 = select by sel, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer rr_last=N_CH-1, so channel 0 has first priority.
  - in_ready is all-zero while rst=1.
- Load enable: ld = !out_valid | out_ready. The output register accepts a new beat whenever it is empty or being drained in the same cycle, giving full throughput of 1 beat/cycle.
- Grant (combinational, one-hot or zero):
  - mode=0: grant[sel]=in_valid[sel] when sel<N_CH. If sel>=N_CH, there is no grant and all in_ready stay 0.
  - mode=1: the first channel with in_valid set, searching rr_last+1, rr_last+2, … with modulo-N_CH wrap.
  - No request means no grant.
- Handshake:
  - in_ready[i] = ld & grant[i].
  - A transfer occurs on channel i when in_valid[i] & in_ready[i].
  - Inputs must hold data stable while valid and not ready. The block never drops a beat.
- On a transfer from channel k at a clk edge:
  - out_data <= channel k data, out_ch <= k, out_valid <= 1.
  - In mode 1, rr_last <= k. In mode 0, rr_last is unchanged.
- On ld with no transfer: out_valid <= 0 and out_data/out_ch hold.
- When out_valid & !out_ready: the output holds all fields and all in_ready stay 0.
- Latency: 1 cycle from the accepting edge to out_valid.
- A mode or sel change takes effect on the next grant evaluation. A beat already in the output register is unaffected, and rr_last is retained across mode changes.
- Single requester in mode 1: that channel is granted every cycle (back-to-back).
- Reset mid-operation: a pending output beat is discarded and no input handshake completes in the reset cycle.
- No arithmetic beyond the modulo-N_CH index wrap. SEL_W-bit indices wrap at N_CH, not at 2^SEL_W.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN.
- When defined:
  - Adds `in_last` (input, N_CH) and `out_last` (output, 1, registered, reset 0).
  - out_last is captured with data.
  - In mode 1, once channel k transfers a beat with in_last[k]=0, the grant locks to k until a beat with in_last[k]=1 transfers. Other requests are ignored while locked.
  - The lock clears on reset.
  - In mode 0, last only passes through.
- When undefined: neither port exists and arbitration is per beat.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
- mode=0, sel=1, in_valid=4'b0001 (ch1 not valid) -> in_ready=0; out_valid falls to 0 after draining.
- mode=1, all four in_valid=1 constantly, out_ready=1, 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; one beat per cycle.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles with ch3 valid -> out_data/out_ch stable, in_ready=0; out_ready=1 -> ch3 beat loaded next edge.
- mode=1, rr_last=1, in_valid=4'b0001 -> ch0 granted (wrap), out_ch=0; then assert rst mid-stream with out_valid=1 -> out_valid=0, out_ch=0, rr_last=3 after edge.
- With STREAM_MUX_LOCK_EN, mode=1: ch1 sends 3 beats with last on the 3rd while ch2 is valid throughout -> out_ch=1,1,1 then 2; out_last=1 on the 3rd beat only.
